// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential array multiplier.
// The optional multiply-accumulate mode is enabled by defining MULT_MAC_EN.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must reach WIDTH/ROWS_PER_CYCLE, the extra cycle that loads p.
  function automatic int cnt_width(input int width, input int rows);
    return $clog2(width / rows + 1);
  endfunction

  function automatic bit params_ok(input int width, input int rows);
    return (width >= 2) && (rows >= 1) && ((width % rows) == 0);
  endfunction

endpackage

// File: rtl/pp_row_gen.sv
// One partial-product row: a_ext gated by a multiplier bit, shifted into place,
// and negated when it is the sign row of a two's-complement multiplier.
module pp_row_gen #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] a_ext,
  input  logic               b_bit,
  input  logic [IDX_W-1:0]   row_idx,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] row
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    shifted = b_bit ? (a_ext << row_idx) : '0;
    row     = shifted;
    if (is_signed && (row_idx == IDX_W'(WIDTH - 1))) begin
      row = ~shifted + ONE;
    end
  end

endmodule

// File: rtl/seq_array_mult.sv
// Multi-cycle array multiplier: ROWS_PER_CYCLE partial-product rows per clock.
// Define MULT_MAC_EN to add the accumulate input (p_new = p_old + a*b).
module seq_array_mult
  import mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
`ifdef MULT_MAC_EN
  input  logic               accumulate,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // out_valid, once high, holds with p stable until out_ready (or rst).
  localparam int PW    = 2 * WIDTH;
  localparam int NSTEP = WIDTH / ROWS_PER_CYCLE;
  localparam int CW    = cnt_width(WIDTH, ROWS_PER_CYCLE);
  localparam int IDX_W = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     a_ext_q, a_ext_d;
  logic [PW-1:0]     p_q, p_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              signed_q, signed_d;

  logic [PW-1:0]     rows    [ROWS_PER_CYCLE];
  logic [IDX_W-1:0]  row_idx [ROWS_PER_CYCLE];
  logic [PW-1:0]     row_sum;
  logic [PW-1:0]     acc_init;
  logic              accept;

  for (genvar j = 0; j < ROWS_PER_CYCLE; j++) begin : g_rows
    assign row_idx[j] = IDX_W'(int'(cnt_q) * ROWS_PER_CYCLE + j);
    pp_row_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_row (
      .a_ext     (a_ext_q),
      .b_bit     (b_q[row_idx[j]]),
      .row_idx   (row_idx[j]),
      .is_signed (signed_q),
      .row       (rows[j])
    );
  end

  always_comb begin
    row_sum = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      row_sum = row_sum + rows[j];
    end
  end

`ifdef MULT_MAC_EN
  assign acc_init = accumulate ? p_q : '0;
`else
  assign acc_init = '0;
`endif

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_ready && in_valid;
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_ext_d  = a_ext_q;
    p_d      = p_q;
    b_d      = b_q;
    signed_d = signed_q;
    case (state_q)
      RUN: begin
        // The cycle after the last row-add only transfers the sum into p.
        if (cnt_q == CW'(NSTEP)) begin
          p_d     = acc_q;
          state_d = DONE;
        end else begin
          acc_d = acc_q + row_sum;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      a_ext_d  = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      b_d      = b;
      signed_d = is_signed;
      acc_d    = acc_init;
      cnt_d    = '0;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_ext_q  <= '0;
      p_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_ext_q  <= a_ext_d;
      p_q      <= p_d;
      b_q      <= b_d;
      signed_q <= signed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (params_ok(WIDTH, ROWS_PER_CYCLE))
        else $error("seq_array_mult: illegal WIDTH/ROWS_PER_CYCLE");
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// Directed bench for seq_array_mult: an R=1 instance and an R=2 instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_array_mult;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        is_signed = 1'b0;
  logic        accumulate = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] p;

  logic        d2_in_valid = 1'b0;
  logic        d2_in_ready;
  logic [7:0]  d2_a = '0;
  logic [7:0]  d2_b = '0;
  logic        d2_is_signed = 1'b0;
  logic        d2_accumulate = 1'b0;
  logic        d2_out_valid;
  logic        d2_out_ready = 1'b0;
  logic [15:0] d2_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_array_mult #(.WIDTH(8), .ROWS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .is_signed  (is_signed),
`ifdef MULT_MAC_EN
    .accumulate (accumulate),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p)
  );

  seq_array_mult #(.WIDTH(8), .ROWS_PER_CYCLE(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (d2_in_valid),
    .in_ready   (d2_in_ready),
    .a          (d2_a),
    .b          (d2_b),
    .is_signed  (d2_is_signed),
`ifdef MULT_MAC_EN
    .accumulate (d2_accumulate),
`endif
    .out_valid  (d2_out_valid),
    .out_ready  (d2_out_ready),
    .p          (d2_p)
  );

  // Accept on a rising edge, then scramble operands to prove they are ignored.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input logic tacc);
    @(negedge clk);
    a = ta; b = tb; is_signed = ts; accumulate = tacc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    is_signed = 1'($urandom_range(0, 1));
    accumulate = 1'($urandom_range(0, 1));
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(output logic [15:0] tp, output int tlat);
    @(negedge clk);
    tlat = 0;
    while (!out_valid && tlat < 40) begin
      @(negedge clk);
      tlat++;
    end
    tp = p;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || d2_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, d2_in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (p !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: p=%h ov=%b ir=%b want 0000/0/1", p, out_valid, in_ready);
    end
    n_checks++;
    if (dut.state_q !== IDLE || dut.cnt_q !== '0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d cnt=%0d want IDLE/0", dut.state_q, dut.cnt_q);
    end
    n_checks++;
    if (d2_p !== 16'h0000 || d2_out_valid !== 1'b0 || d2_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs_r2: p=%h ov=%b ir=%b want 0000/0/1", d2_p, d2_out_valid,
               d2_in_ready);
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] rp;
    int          lat;
    start_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_result(rp, lat);
    n_checks++;
    if (rp !== 16'hFE01) begin
      n_fail++;
      $display("FAIL unsigned_ff_ff: p=%h want fe01", rp);
    end
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL unsigned_latency: got %0d want 9", lat);
    end
    pop();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_to_idle: ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
    start_op(8'h00, 8'h37, 1'b0, 1'b0);
    wait_result(rp, lat);
    n_checks++;
    if (rp !== 16'h0000) begin
      n_fail++;
      $display("FAIL unsigned_zero: p=%h want 0000", rp);
    end
    pop();
  endtask

  task automatic test_signed();
    logic [7:0]  va [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [7:0]  vb [3] = '{8'h80, 8'h01, 8'h80};
    logic [15:0] ve [3] = '{16'h4000, 16'hFFFF, 16'hC080};
    logic [15:0] rp;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], 1'b1, 1'b0);
      wait_result(rp, lat);
      n_checks++;
      if (rp !== ve[i] || lat !== 9) begin
        n_fail++;
        $display("FAIL signed_%0d: p=%h lat=%0d want %h lat=9", i, rp, lat, ve[i]);
      end
      pop();
    end
  endtask

  task automatic test_r2();
    int lat;
    @(negedge clk);
    d2_a = 8'h80; d2_b = 8'h02; d2_is_signed = 1'b0; d2_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d2_in_valid = 1'b0; d2_a = 8'hA5; d2_b = 8'h5A;
    @(negedge clk);
    lat = 0;
    while (!d2_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (d2_p !== 16'h0100 || lat !== 5) begin
      n_fail++;
      $display("FAIL r2_unsigned: p=%h lat=%0d want 0100 lat=5", d2_p, lat);
    end
    d2_out_ready = 1'b1;
    @(negedge clk);
    d2_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rp;
    int          lat;
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_result(rp, lat);
    n_checks++;
    if (rp !== 16'h03A8) begin
      n_fail++;
      $display("FAIL bp_first: p=%h want 03a8", rp);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (p !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: p=%h ov=%b ir=%b want 03a8/1/0", i, p, out_valid, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd5; is_signed = 1'b0; accumulate = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'hEE; b = 8'hDD;
    wait_result(rp, lat);
    n_checks++;
    if (rp !== 16'h000F || lat !== 9) begin
      n_fail++;
      $display("FAIL b2b_second: p=%h lat=%0d want 000f lat=9", rp, lat);
    end
    pop();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] rp;
    int          lat;
    start_op(8'h55, 8'h66, 1'b0, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (p !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL mid_run_reset: p=%h ov=%b ir=%b st=%0d want 0000/0/0/IDLE", p, out_valid,
               in_ready, dut.state_q);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
    start_op(8'h02, 8'h03, 1'b0, 1'b0);
    wait_result(rp, lat);
    n_checks++;
    if (rp !== 16'h0006 || lat !== 9) begin
      n_fail++;
      $display("FAIL post_reset_op: p=%h lat=%0d want 0006 lat=9", rp, lat);
    end
    pop();
  endtask

`ifdef MULT_MAC_EN
  task automatic test_mac();
    logic [7:0]  va [3] = '{8'h10, 8'h02, 8'hFF};
    logic [7:0]  vb [3] = '{8'h10, 8'h03, 8'hFF};
    logic        vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] ve [3] = '{16'h0100, 16'h0106, 16'hFF07};
    logic [15:0] rp;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], 1'b0, vc[i]);
      wait_result(rp, lat);
      n_checks++;
      if (rp !== ve[i]) begin
        n_fail++;
        $display("FAIL mac_%0d: p=%h want %h", i, rp, ve[i]);
      end
      pop();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_r2();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MULT_MAC_EN
    test_mac();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
